// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
//
// This block sequences one shared combinational keyexpand instance to build
// the full AES-128 round-key schedule, one expansion step per clock. Round 0
// is the cipher key itself, and rounds 1..NR are the expanded keys. Every
// round key is stored in a local key bank. The round datapath reads the bank
// through a registered read port.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       request expansion of key_in; only taken while ready=1
//   key_in      cipher key (round-0 key), byte15 in bits [127:120]
//   ready       idle and able to accept start
//   busy        expansion in progress
//   done        one-cycle pulse after the last round key is written
//   keys_valid  bank holds a complete schedule for the last accepted key
//   ke_key      key presented to the external keyexpand .key input
//   ke_rc       round index presented to the external keyexpand .rc input
//   ke_keyout   combinational result from the external keyexpand .keyout
//   rd_en       read strobe
//   rd_round    round index to read, 0..NR
//   rd_key      registered read data
//   rd_valid    high the cycle after rd_en
//   rd_err      with rd_valid: index out of range or no valid schedule

module key_schedule_ctrl #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [KW-1:0] key_in,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          keys_valid,
    output logic [KW-1:0] ke_key,
    output logic [3:0]    ke_rc,
    input  logic [KW-1:0] ke_keyout,
    input  logic          rd_en,
    input  logic [3:0]    rd_round,
    output logic [KW-1:0] rd_key,
    output logic          rd_valid,
    output logic          rd_err
);

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [KW-1:0] cur_q;
    logic          keys_valid_q;
    logic          done_q;
    logic [KW-1:0] rd_key_q;
    logic          rd_valid_q;
    logic          rd_err_q;
    logic [KW-1:0] bank [0:NR];

    logic accept;
    logic expanding;
    logic last_step;

    assign accept    = (state_q == StIdle) && start;
    assign expanding = (state_q == StExpand);
    assign last_step = expanding && (cnt_q == 4'(NR - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start)     state_d = StExpand;
            StExpand: if (last_step) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs. The keyexpand inputs are held at zero while idle so that the
    // shared instance does not toggle.
    always_comb begin
        ready      = (state_q == StIdle);
        busy       = expanding;
        done       = done_q;
        keys_valid = keys_valid_q;
        ke_key     = expanding ? cur_q : '0;
        ke_rc      = expanding ? cnt_q : 4'd0;
        rd_key     = rd_key_q;
        rd_valid   = rd_valid_q;
        rd_err     = rd_err_q;
    end

    // Expansion datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            cur_q        <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= last_step;
            if (accept) begin
                cur_q        <= key_in;
                cnt_q        <= 4'd0;
                keys_valid_q <= 1'b0;
            end else if (expanding) begin
                cur_q <= ke_keyout;
                cnt_q <= cnt_q + 4'd1;
                if (last_step) begin
                    keys_valid_q <= 1'b1;
                end
            end
        end
    end

    // The key bank has no reset. While keys_valid is low, its contents cannot
    // be read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept) begin
                bank[0] <= key_in;
            end else if (expanding) begin
                bank[cnt_q + 4'd1] <= ke_keyout;
            end
        end
    end

    // Read port. A read on the same edge as an accepted start still sees the
    // old keys_valid, so it returns the previous schedule.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_key_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                if ((rd_round <= 4'(NR)) && keys_valid_q) begin
                    rd_key_q <= bank[rd_round];
                    rd_err_q <= 1'b0;
                end else begin
                    rd_key_q <= '0;
                    rd_err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Sequencer that drives one shared combinational keyexpand instance to generate the full AES-128 round-key set (round 0 plus NR expanded keys) from a 128-bit cipher key. It runs one expansion step per clock and stores every round key in an internal key bank. A registered read port lets the round datapath fetch any round key by index. It sits between key load and the encrypt round loop.

Parameters:
NR, 10, number of expansions (last round index); legal 1..10 (rcon table limit)
KW, 128, key width in bits; fixed at 128, bytes packed byte15 = bits[127:120] … byte0 = bits[7:0]

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous active-high reset
start  in  1  request expansion of key_in; sampled only when ready=1
key_in  in  KW  cipher key (round-0 key), byte15 = MSB
ready  out  1  1 when idle and able to accept start
busy  out  1  1 while expansion in progress
done  out  1  one-cycle pulse when the last round key is written
keys_valid  out  1  key bank holds a complete schedule for the last accepted key
ke_key  out  KW  key driven to the external keyexpand .key input
ke_rc  out  4  round index driven to the external keyexpand .rc input
ke_keyout  in  KW  combinational result from the external keyexpand .keyout output
rd_en  in  1  read strobe
rd_round  in  4  round index to read, 0..NR
rd_key  out  KW  registered read data
rd_valid  out  1  pulses 1 cycle after rd_en
rd_err  out  1  with rd_valid: rd_round > NR, or keys_valid=0

Behaviour:
- Reset (synchronous, active-high): state=IDLE, cnt=0, ready=1, busy=0, done=0, keys_valid=0, rd_key=0, rd_valid=0, rd_err=0, ke_key=0, ke_rc=0. Key bank contents are don't-care (no clear required); keys_valid=0 makes them unreadable.
- States: IDLE, EXPAND.
- IDLE, start=1 on an edge: bank[0]<=key_in, cur<=key_in, cnt<=0, keys_valid<=0, go to EXPAND. ready=0 and busy=1 from the next cycle.
- EXPAND each cycle: ke_key=cur, ke_rc=cnt (combinational from registers). On the edge: bank[cnt+1]<=ke_keyout, cur<=ke_keyout, cnt<=cnt+1.
- On the edge where cnt==NR-1: go to IDLE, keys_valid<=1, done<=1 for exactly one cycle.
- Latency: start edge E0, writes at E1..E_NR; done and keys_valid are high after E_NR (E10 for NR=10). Next start is accepted at E_NR+1 at the earliest, back-to-back.
- ke_rc convention: ke_rc=i produces round key i+1 (rc=0 gives rcon 0x01).
- start while busy is ignored; it is neither queued nor an error.
- Read port: on an edge with rd_en=1, rd_valid<=1. If rd_round<=NR and keys_valid=1: rd_key<=bank[rd_round], rd_err<=0. Otherwise rd_key<=0, rd_err<=1. When rd_en=0: rd_valid<=0 and rd_key holds its value.
- A read in the same cycle as an accepted start uses the pre-start keys_valid, i.e. the old schedule.
- Reads during EXPAND return rd_err=1.
- Reset mid-EXPAND: aborts to IDLE, keys_valid=0, and the next start begins cleanly.
- ke_key is 0 in IDLE, to avoid toggling the shared keyexpand.

Test Plan:
- FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, start pulse -> done exactly 10 cycles after the start edge; read round 1 = a0fafe17_88542cb1_23a33939_2a6c7605; round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6; round 0 = the key.
- All-zero key -> round 1 = 62636363_62636363_62636363_62636363; round 2 = 9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa; round 10 = b4ef5bcb_3e92e211_23e951cf_6f8f188e.
- Key 69 20 e2 99 a5 20 2a 6d 65 6e 63 68 69 74 6f 2a (MSB first) -> round 1 = fa880760_5fa82d0d_3ac64e65_53b2214f; round 10 = ae127cda_db479ba8_f220df3d_4858f6b1.
- Second start pulses during busy -> ignored: done fires once and the schedule matches the first key. A reads during busy -> rd_err=1.
- Read rd_round=11 with keys_valid=1 -> rd_valid=1, rd_err=1, rd_key=0. Read with rd_en=0 -> rd_valid=0 and rd_key unchanged.
- Reset asserted at cnt=5 -> next cycle ready=1, keys_valid=0, done never pulses. A fresh start then yields the correct FIPS schedule.
